// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI frames into register-bus transactions.
// The command byte sets the direction and start address. Each later byte is
// either a burst write, or the trigger that prefetches the next read byte.
module spi_reg_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              byte_rdy,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_latch,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_LOAD, RD_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_latch_q, tx_latch_d;
  logic               err_q, err_d;
  logic               end_pend_q, end_pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Two synchroniser flops per async input, plus a third for edge detection.
  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic br_s1_q, br_s2_q, br_s3_q;

  logic frame_start, frame_fall, frame_end, byte_evt;
  logic bus_state, ack_expired, bus_done;

  assign frame_start = ss_s2_q & ~ss_s3_q;
  assign frame_fall  = ~ss_s2_q & ss_s3_q;
  assign byte_evt    = br_s2_q & ~br_s3_q;
  // A frame end seen mid-access is remembered until the access finishes.
  assign frame_end   = frame_fall | end_pend_q;

  assign bus_state   = (state_q == WR_BUS) || (state_q == RD_BUS);
  assign ack_expired = bus_state && (cnt_q == CNT_W'(ACK_TIMEOUT)) && !reg_ack;
  assign bus_done    = bus_state && (reg_ack || (cnt_q == CNT_W'(ACK_TIMEOUT)));

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_byte_d  = tx_byte_q;
    tx_latch_d = 1'b0;
    err_d      = err_q;
    end_pend_d = end_pend_q;
    cnt_d      = '0;

    if (bus_state && !bus_done) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        end_pend_d = 1'b0;
        if (frame_start) begin
          err_d   = 1'b0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (frame_end) begin
          state_d = IDLE;
        end else if (byte_evt) begin
          addr_d = rx_byte[ADDR_W-1:0];
          if (rx_byte[7]) begin
            state_d = RD_BUS;
          end else begin
            tx_byte_d  = 8'h00;
            tx_latch_d = 1'b1;
            state_d    = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (frame_end) begin
          state_d = IDLE;
        end else if (byte_evt) begin
          wdata_d    = rx_byte;
          tx_byte_d  = 8'h00;
          tx_latch_d = 1'b1;
          state_d    = WR_BUS;
        end
      end
      WR_BUS: begin
        if (frame_fall) end_pend_d = 1'b1;
        if (byte_evt) err_d = 1'b1;
        if (bus_done) begin
          if (ack_expired) err_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = frame_end ? IDLE : WR_WAIT;
        end
      end
      RD_BUS: begin
        if (frame_fall) end_pend_d = 1'b1;
        if (byte_evt) err_d = 1'b1;
        if (bus_done) begin
          if (ack_expired) begin
            err_d     = 1'b1;
            tx_byte_d = 8'hEE;
          end else begin
            tx_byte_d = reg_rdata;
          end
          addr_d  = addr_q + 1'b1;
          state_d = frame_end ? IDLE : RD_LOAD;
        end
      end
      RD_LOAD: begin
        if (byte_evt) err_d = 1'b1;
        if (frame_end) begin
          state_d = IDLE;
        end else begin
          tx_latch_d = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (frame_end) begin
          state_d = IDLE;
        end else if (byte_evt) begin
          state_d = RD_BUS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and synchroniser registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      tx_byte_q  <= 8'h00;
      tx_latch_q <= 1'b0;
      err_q      <= 1'b0;
      end_pend_q <= 1'b0;
      cnt_q      <= '0;
      ss_s1_q    <= 1'b0;
      ss_s2_q    <= 1'b0;
      ss_s3_q    <= 1'b0;
      br_s1_q    <= 1'b0;
      br_s2_q    <= 1'b0;
      br_s3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_byte_q  <= tx_byte_d;
      tx_latch_q <= tx_latch_d;
      err_q      <= err_d;
      end_pend_q <= end_pend_d;
      cnt_q      <= cnt_d;
      ss_s1_q    <= ss;
      ss_s2_q    <= ss_s1_q;
      ss_s3_q    <= ss_s2_q;
      br_s1_q    <= byte_rdy;
      br_s2_q    <= br_s1_q;
      br_s3_q    <= br_s2_q;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign tx_latch  = tx_latch_q;
  assign reg_req   = bus_state;
  assign reg_we    = (state_q == WR_BUS);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: scoreboarded bus accesses and tx latches.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss = 1'b0;
  logic       byte_rdy = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_latch;
  logic       reg_req;
  logic       reg_we;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;
  logic       busy;
  logic       err;

  spi_reg_ctrl #(.ADDR_W(7), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .byte_rdy(byte_rdy), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .tx_latch(tx_latch), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] tx_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_latch = 0;
  int n_bus = 0;
  int ack_delay = 2;
  bit ack_en = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-bus responder: acks after ack_delay waiting cycles, rdata = addr + 0x10.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      reg_ack = 1'b0;
      if (rst_n && reg_req) begin
        if (ack_en && wait_cnt >= ack_delay) begin
          reg_ack   = 1'b1;
          reg_rdata = 8'h10 + {1'b0, reg_addr};
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every latch and every completed bus access.
  initial begin : monitor
    bus_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_latch) begin
          n_latch++;
          check_val("latch_expected", 32'(tx_q.size() > 0), 1);
          if (tx_q.size() > 0) check_val("tx_byte", 32'(tx_byte), 32'(tx_q.pop_front()));
        end
        if (reg_req && reg_ack) begin
          n_bus++;
          check_val("bus_expected", 32'(bus_q.size() > 0), 1);
          if (bus_q.size() > 0) begin
            b = bus_q.pop_front();
            check_val("bus_we", 32'(reg_we), 32'(b.we));
            check_val("bus_addr", 32'(reg_addr), 32'(b.addr));
            if (b.we) check_val("bus_wdata", 32'(reg_wdata), 32'(b.data));
          end
        end
      end
    end
  end

  task automatic push_bus(input logic we, input logic [6:0] addr, input logic [7:0] data);
    bus_t b;
    b.we = we; b.addr = addr; b.data = data;
    bus_q.push_back(b);
  endtask

  task automatic wait_latch(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (tx_latch) ok = 1'b1;
    end
    check_val(tag, 32'(ok), 1);
  endtask

  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (reg_req) ok = 1'b1;
    end
    check_val(tag, 32'(ok), 1);
  endtask

  // Slave model for one byte: hold byte_rdy until the latch, then leave a safe gap.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    byte_rdy = 1'b1;
    wait_latch("latch_wait");
    byte_rdy = 1'b0;
    repeat (ack_delay + 8) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_stop();
    ss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin : main
    int l0, b0, req_len;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx_byte", 32'(tx_byte), 0);
    check_val("rst_tx_latch", 32'(tx_latch), 0);
    check_val("rst_reg_req", 32'(reg_req), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_reg_addr", 32'(reg_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write frame: 0x05, 0xA1, 0xB2
    ack_delay = 2;
    l0 = n_latch;
    push_bus(1'b1, 7'h05, 8'hA1);
    push_bus(1'b1, 7'h06, 8'hB2);
    for (int i = 0; i < 3; i++) tx_q.push_back(8'h00);
    frame_begin();
    check_val("busy_in_frame", 32'(busy), 1);
    send_byte(8'h05);
    send_byte(8'hA1);
    send_byte(8'hB2);
    frame_stop();
    check_val("wr_latches", 32'(n_latch - l0), 3);
    check_val("wr_err", 32'(err), 0);
    check_val("wr_idle", 32'(busy), 0);
    check_val("wr_bus_left", 32'(bus_q.size()), 0);

    // Read burst: 0x83, 0x00, 0x00 -> reads 3, 4, 5
    push_bus(1'b0, 7'h03, 8'h00);
    push_bus(1'b0, 7'h04, 8'h00);
    push_bus(1'b0, 7'h05, 8'h00);
    tx_q.push_back(8'h13);
    tx_q.push_back(8'h14);
    tx_q.push_back(8'h15);
    frame_begin();
    send_byte(8'h83);
    send_byte(8'h00);
    send_byte(8'h00);
    frame_stop();
    check_val("rd_err", 32'(err), 0);
    check_val("rd_idle", 32'(busy), 0);
    check_val("rd_tx_left", 32'(tx_q.size()), 0);

    // Address wrap: 0x7F then 0x00
    push_bus(1'b1, 7'h7F, 8'h11);
    push_bus(1'b1, 7'h00, 8'h22);
    for (int i = 0; i < 3; i++) tx_q.push_back(8'h00);
    frame_begin();
    send_byte(8'h7F);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_stop();
    check_val("wrap_bus_left", 32'(bus_q.size()), 0);

    // Timeout: read 0x80, never acked
    ack_en = 1'b0;
    tx_q.push_back(8'hEE);
    frame_begin();
    @(negedge clk);
    rx_byte  = 8'h80;
    byte_rdy = 1'b1;
    wait_req("to_req_rise");
    req_len = 0;
    while (reg_req && req_len < 100) begin
      req_len++;
      @(negedge clk);
    end
    check_val("to_req_len", 32'(req_len), 16);
    wait_latch("to_latch_wait");
    byte_rdy = 1'b0;
    check_val("to_err_set", 32'(err), 1);
    frame_stop();
    check_val("to_err_sticky", 32'(err), 1);
    check_val("to_idle", 32'(busy), 0);
    ack_en = 1'b1;
    frame_begin();
    check_val("to_err_cleared", 32'(err), 0);
    frame_stop();

    // Overrun: second byte event while the write waits for its ack
    ack_delay = 10;
    l0 = n_latch;
    b0 = n_bus;
    push_bus(1'b1, 7'h02, 8'h5A);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    frame_begin();
    send_byte(8'h02);
    @(negedge clk);
    rx_byte  = 8'h5A;
    byte_rdy = 1'b1;
    wait_latch("ov_latch_wait");
    byte_rdy = 1'b0;
    @(negedge clk);
    rx_byte  = 8'h77;
    byte_rdy = 1'b1;
    repeat (3) @(negedge clk);
    byte_rdy = 1'b0;
    repeat (25) @(negedge clk);
    check_val("ov_err", 32'(err), 1);
    check_val("ov_latches", 32'(n_latch - l0), 2);
    check_val("ov_writes", 32'(n_bus - b0), 1);
    frame_stop();
    check_val("ov_idle", 32'(busy), 0);

    // Abort: ss falls during RD_BUS -> access completes, no latch
    ack_delay = 5;
    l0 = n_latch;
    push_bus(1'b0, 7'h04, 8'h00);
    frame_begin();
    @(negedge clk);
    rx_byte  = 8'h84;
    byte_rdy = 1'b1;
    wait_req("ab_req_rise");
    ss = 1'b0;
    repeat (20) @(negedge clk);
    byte_rdy = 1'b0;
    check_val("ab_idle", 32'(busy), 0);
    check_val("ab_no_latch", 32'(n_latch - l0), 0);
    check_val("ab_bus_done", 32'(bus_q.size()), 0);
    check_val("ab_err", 32'(err), 0);
    repeat (4) @(negedge clk);

    // Reset asserted mid-WR_BUS
    ack_delay = 30;
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    frame_begin();
    send_byte(8'h01);
    @(negedge clk);
    rx_byte  = 8'h33;
    byte_rdy = 1'b1;
    wait_latch("rs_latch_wait");
    byte_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rs_req_before", 32'(reg_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rs_req", 32'(reg_req), 0);
    check_val("rs_busy", 32'(busy), 0);
    check_val("rs_we", 32'(reg_we), 0);
    check_val("rs_addr", 32'(reg_addr), 0);
    check_val("rs_wdata", 32'(reg_wdata), 0);
    check_val("rs_tx_byte", 32'(tx_byte), 0);
    ss = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 2;
    repeat (6) @(negedge clk);
    check_val("rs_still_idle", 32'(busy), 0);

    check_val("end_tx_left", 32'(tx_q.size()), 0);
    check_val("end_bus_left", 32'(bus_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access sequencer that sits behind the SPI slave byte interface in the system clock domain. It turns each SPI frame into register-bus transactions. The first byte of a frame is a command (R/W flag plus start address); each further byte is a burst write or a prefetched burst read with address auto-increment. It also acknowledges every received byte to the slave by loading the transmit byte and pulsing the latch.

## Interface
- `ADDR_W`, default 7: register address width, must be 1..7; command bits above `ADDR_W` are ignored.
- `ACK_TIMEOUT`, default 15: number of `clk` cycles `reg_req` may wait for `reg_ack` before the access is aborted.

Ports:
- `clk`  in  1: system clock; everything is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ss`  in  1: slave select from the pad; high means a frame is active; asynchronous to `clk`.
- `byte_rdy`  in  1: byte-received flag from the SPI slave; asynchronous; stays high until `tx_latch`.
- `rx_byte`  in  8: received byte; stable while `byte_rdy` is high.
- `tx_byte`  out  8: byte loaded into the slave shift register on `tx_latch`.
- `tx_latch`  out  1: one-cycle pulse; loads `tx_byte` and clears the slave's `byte_rdy`.
- `reg_req`  out  1: bus request; held until `reg_ack` or timeout.
- `reg_we`  out  1: 1 = write, 0 = read; valid while `reg_req` is high.
- `reg_addr`  out  `ADDR_W`: bus address.
- `reg_wdata`  out  8: write data.
- `reg_rdata`  in  8: read data; sampled in the `reg_ack` cycle.
- `reg_ack`  in  1: single-cycle bus completion.
- `busy`  out  1: high whenever the state is not IDLE.
- `err`  out  1: sticky; set on overrun or timeout; cleared at the next frame start.

## Operation
- **Synchronisers:** `ss` and `byte_rdy` each pass through 2 flops. A rising edge on synced `ss` is a frame start; a falling edge is a frame end. A rising edge on synced `byte_rdy` is a byte event, with `rx_byte` captured in that cycle.
- **States:** IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_LOAD, RD_WAIT.
- **IDLE:** on frame start, clear `err` and go to CMD. Byte events in IDLE are ignored.
- **CMD:** on a byte event, load `addr <= rx_byte[ADDR_W-1:0]`.
  - If `rx_byte[7]` = 0 (write): pulse `tx_latch` with `tx_byte` = 0x00, then go to WR_WAIT.
  - If `rx_byte[7]` = 1 (read): go to RD_BUS without latching yet.
- **WR_WAIT:** on a byte event, capture `reg_wdata <= rx_byte`, pulse `tx_latch` with `tx_byte` = 0x00, and go to WR_BUS.
- **WR_BUS:** assert `reg_req` with `reg_we` = 1. On `reg_ack` or timeout, `addr++` and go to WR_WAIT.
- **RD_BUS:** assert `reg_req` with `reg_we` = 0. On `reg_ack`, `tx_byte <= reg_rdata`; on timeout, `tx_byte <= 0xEE` and set `err`. Then `addr++` and go to RD_LOAD.
- **RD_LOAD:** pulse `tx_latch` and go to RD_WAIT.
- **RD_WAIT:** on a byte event (master clocked out the prefetched byte), go to RD_BUS to prefetch the next address.
- **Address arithmetic:** `addr` increments modulo 2^`ADDR_W`; 2^`ADDR_W`-1 wraps to 0.
- **Overrun:** a byte event in WR_BUS, RD_BUS or RD_LOAD sets `err`. The byte is dropped, with no latch and no bus access.
- **Timeout:** a counter runs while `reg_req` is high. When it reaches `ACK_TIMEOUT` without `reg_ack`, drop `reg_req` in the next cycle, set `err`, and proceed as if acked. A write is lost.
- **Frame end:**
  - In CMD, WR_WAIT or RD_WAIT: go to IDLE in the same cycle.
  - In a bus state: finish the bus access (ack or timeout), then go to IDLE with no further latch.
  - A frame end has priority over a simultaneous byte event.
- **Reset:** all state is cleared immediately, including mid-transaction.
  - State = IDLE.
  - `tx_byte` = 0x00, `tx_latch` = 0, `reg_req` = 0, `reg_we` = 0, `reg_addr` = 0, `reg_wdata` = 0, `busy` = 0, `err` = 0.
  - Synchroniser flops = 0.

## Timing
- Input edge to detected event: 2 `clk` cycles, from the first flop sampling high to the edge being detected.
- Write byte: byte event in cycle T gives `tx_latch` = 1 and `reg_req` = 1 in T+1. `reg_req` stays high up to and including the `reg_ack` cycle and drops in the following cycle.
- Read: `reg_ack` in cycle A gives `tx_byte` valid at A+1 and `tx_latch` = 1 at A+2, so `tx_byte` is stable one cycle before the latch edge.
- `tx_latch` is exactly 1 cycle wide. `tx_byte` holds its value until the next load.
- Master pacing: the gap between the last SCLK of one byte and the first SCLK of the next must exceed (4 + bus latency) `clk` cycles, otherwise an overrun is reported.

## Test plan
- Write frame: `ss` high, bytes 0x05, 0xA1, 0xB2, `ss` low -> bus writes (addr 5, 0xA1) then (addr 6, 0xB2); 3 `tx_latch` pulses; `err` = 0; IDLE at end.
- Read burst with `reg_rdata` = addr+0x10, `ss` high, bytes 0x83, 0x00, 0x00 -> reads at addr 3, 4, 5; `tx_byte` sequence 0x13, 0x14, 0x15.
- Wrap: write command 0x7F followed by 2 data bytes -> writes at addr 0x7F then 0x00.
- Timeout: read 0x80 with `reg_ack` never asserted -> `reg_req` drops after 16 cycles; `tx_byte` = 0xEE; `err` = 1. The next frame start clears `err`.
- Overrun: hold `reg_ack` off for 10 cycles and inject a second byte event during WR_BUS -> `err` = 1; only 1 write occurs; the dropped byte produces no `tx_latch`.
- Abort and reset: `ss` falls during RD_BUS -> ack completes, no latch, IDLE. `rst_n` low mid-WR_BUS -> `reg_req` = 0 and `busy` = 0 asynchronously.
